stream_width_packer: RTL and testbench

//   Packs narrow pixel-stream beats (e.g. 16-bit Boson pixels) into RATIO-wide words before the

---
 rtl/stream_width_packer.sv | 92 +++++++++
 tb/tb_stream_width_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_width_packer.sv
// stream_width_packer: gathers RATIO narrow input beats into one wide output word.
// A packet ending mid-word is flushed with the unused upper lanes zeroed.
// The output register is the only output stage, so stream_m_* never depend
// combinationally on the input side.
module stream_width_packer #(
    parameter  int IW    = 16,
    parameter  int RATIO = 2,
    localparam int OW    = IW * RATIO,
    localparam int CW    = $clog2(RATIO + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] stream_s_data_i,
    input  logic          stream_s_valid_i,
    input  logic          stream_s_last_i,
    output logic          stream_s_ready_o,
    output logic [OW-1:0] stream_m_data_o,
    output logic          stream_m_valid_o,
    input  logic          stream_m_ready_i,
    output logic          stream_m_last_o,
    output logic [CW-1:0] stream_m_fill_o,
    output logic [15:0]   pad_count_o
);

    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0] cnt;
    logic [OW-1:0] acc;
    logic [OW-1:0] word;
    logic          accept;
    logic          complete;

    // Input is taken whenever the output register is empty or being drained this cycle.
    always_comb begin
        stream_s_ready_o = !rst && (!stream_m_valid_o || stream_m_ready_i);
        accept           = stream_s_valid_i && stream_s_ready_o;
        complete         = accept && ((cnt == LAST_LANE) || stream_s_last_i);
    end

    // Assemble the outgoing word: held lanes below cnt, the new beat at cnt, zeros above.
    always_comb begin
        word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(cnt)) begin
                word[k*IW +: IW] = acc[k*IW +: IW];
            end else if (k == int'(cnt)) begin
                word[k*IW +: IW] = stream_s_data_i;
            end
        end
    end

    // Accumulator and lane counter; cleared whenever a word is handed to the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (complete) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            acc[int'(cnt)*IW +: IW] <= stream_s_data_i;
            cnt                     <= cnt + CW'(1);
        end
    end

    // Output register: reloads on a completing beat, otherwise empties once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream_m_data_o  <= '0;
            stream_m_valid_o <= 1'b0;
            stream_m_last_o  <= 1'b0;
            stream_m_fill_o  <= '0;
        end else if (complete) begin
            stream_m_data_o  <= word;
            stream_m_valid_o <= 1'b1;
            stream_m_last_o  <= stream_s_last_i;
            stream_m_fill_o  <= cnt + CW'(1);
        end else if (stream_m_ready_i) begin
            stream_m_valid_o <= 1'b0;
        end
    end

    // Count words that left with fewer than RATIO lanes filled, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_count_o <= '0;
        end else if (complete && (cnt != LAST_LANE) && (pad_count_o != 16'hFFFF)) begin
            pad_count_o <= pad_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_width_packer.sv
// tb_stream_width_packer: directed and randomised stimulus, with a packet-level
// reference model (beats grouped into words by count or packet end) checked every cycle.
module tb_stream_width_packer;

    localparam int IW    = 16;
    localparam int RATIO = 2;
    localparam int OW    = IW * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] m_fill;
    logic [15:0]   pad_count;

    logic rand_mode = 1'b0;
    logic rnd_ready = 1'b0;
    logic ready_fix = 1'b1;
    assign m_ready = rand_mode ? rnd_ready : ready_fix;

    stream_width_packer #(.IW(IW), .RATIO(RATIO)) dut (
        .clk              (clk),
        .rst              (rst),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_last_i  (s_last),
        .stream_s_ready_o (s_ready),
        .stream_m_data_o  (m_data),
        .stream_m_valid_o (m_valid),
        .stream_m_ready_i (m_ready),
        .stream_m_last_o  (m_last),
        .stream_m_fill_o  (m_fill),
        .pad_count_o      (pad_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected words derived from the accepted beat sequence.
    typedef struct {
        logic [OW-1:0] d;
        logic          last;
        logic [CW-1:0] fill;
    } word_t;

    word_t         exp_q[$];
    logic [IW-1:0] pend[$];
    int            pad_model  = 0;
    int            words_out  = 0;
    int            cont_stall = 0;
    logic          cont_mode  = 1'b0;
    logic          expect_valid = 1'b0;
    logic          stall_prev   = 1'b0;
    logic [OW-1:0] held_d;
    logic          held_last;
    logic [CW-1:0] held_fill;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", 64'(s_ready), 64'd0);
            exp_q.delete();
            pend.delete();
            pad_model    = 0;
            expect_valid = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
            chk("pad_count", 64'(pad_count), 64'(pad_model));
            if (expect_valid) chk("latency_valid", 64'(m_valid), 64'd1);
            if (stall_prev) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(held_d));
                chk("stall_last", 64'(m_last), 64'(held_last));
                chk("stall_fill", 64'(m_fill), 64'(held_fill));
            end
            if (cont_mode && s_valid && !s_ready) cont_stall++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data), 64'hDEAD_0000_0000);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_data", 64'(m_data), 64'(w.d));
                    chk("word_last", 64'(m_last), 64'(w.last));
                    chk("word_fill", 64'(m_fill), 64'(w.fill));
                end
                words_out++;
            end
            stall_prev   = m_valid && !m_ready;
            held_d       = m_data;
            held_last    = m_last;
            held_fill    = m_fill;
            expect_valid = 1'b0;
            if (s_valid && s_ready) begin
                pend.push_back(s_data);
                if (pend.size() == RATIO || s_last) begin
                    word_t w;
                    w.d = '0;
                    for (int k = 0; k < pend.size(); k++) w.d[k*IW +: IW] = pend[k];
                    w.last = s_last;
                    w.fill = CW'(pend.size());
                    exp_q.push_back(w);
                    if (pend.size() < RATIO && pad_model < 65535) pad_model++;
                    pend.delete();
                    expect_valid = 1'b1;
                end
            end
        end
    end

    // Drive one beat from posedge+1 and return at posedge+1 after it is accepted.
    task automatic send(input logic [IW-1:0] d, input logic l);
        bit done;
        done    = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int t0, w0, gap;
        // Reset with valid asserted
        rst = 1'b1;
        s_valid = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_m_data", 64'(m_data), 64'd0);
            chk("rst_m_last", 64'(m_last), 64'd0);
            chk("rst_m_fill", 64'(m_fill), 64'd0);
            chk("rst_pad", 64'(pad_count), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        #1;

        // Two-beat packet
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        @(negedge clk);
        chk("pair_valid", 64'(m_valid), 64'd1);
        chk("pair_data", 64'(m_data), 64'h2222_1111);
        chk("pair_fill", 64'(m_fill), 64'd2);
        chk("pair_last", 64'(m_last), 64'd1);
        chk("pair_pad", 64'(pad_count), 64'd0);
        @(posedge clk);
        #1;

        // Odd-length packet
        send(16'hA001, 1'b0);
        send(16'hA002, 1'b0);
        @(negedge clk);
        chk("odd_w0_data", 64'(m_data), 64'hA002_A001);
        chk("odd_w0_fill", 64'(m_fill), 64'd2);
        chk("odd_w0_last", 64'(m_last), 64'd0);
        @(posedge clk);
        #1;
        send(16'hA003, 1'b1);
        @(negedge clk);
        chk("odd_w1_data", 64'(m_data), 64'h0000_A003);
        chk("odd_w1_fill", 64'(m_fill), 64'd1);
        chk("odd_w1_last", 64'(m_last), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("odd_pad", 64'(pad_count), 64'd1);
        @(posedge clk);
        #1;

        // Continuous streaming at full rate
        w0 = words_out;
        cont_mode = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 1024; i++) send(IW'(16'h4000 + i), i == 1023);
        chk("cont_cycles", 64'(cyc - t0), 64'd1024);
        cont_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cont_words", 64'(words_out - w0), 64'd512);
        chk("cont_stalls", 64'(cont_stall), 64'd0);

        // Random backpressure and input gaps
        rand_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            gap = $urandom_range(0, 3);
            if (gap == 3) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(IW'($urandom), $urandom_range(0, 4) == 0);
        end
        rand_mode = 1'b0;
        ready_fix = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_valid_idle", 64'(m_valid), 64'd0);

        // Reset with lane 0 filled
        send(16'h00CC, 1'b0);
        pulse_reset();
        // Reset with a stalled word
        ready_fix = 1'b0;
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b0);
        @(negedge clk);
        chk("stalled_valid", 64'(m_valid), 64'd1);
        chk("stalled_data", 64'(m_data), 64'h00BB_00AA);
        @(posedge clk);
        #1;
        pulse_reset();
        ready_fix = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(m_valid), 64'd0);
        chk("post_rst_pad", 64'(pad_count), 64'd0);
        @(posedge clk);
        #1;
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        @(negedge clk);
        chk("post_rst_data", 64'(m_data), 64'h0006_0005);
        chk("post_rst_fill", 64'(m_fill), 64'd2);
        chk("post_rst_last", 64'(m_last), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
